// File: rtl/com_port_controller_pkg.sv
// Shared definitions for the host communication port controller.
//   COM_WIDTH          : width of a host word and of a data memory word.
//   DEFAULT_ADDR_WIDTH : default data memory address width.
//   com_state_t        : controller state encoding, also exported for debug.
package com_port_controller_pkg;

  localparam int COM_WIDTH          = 16;
  localparam int DEFAULT_ADDR_WIDTH = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_KICK   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_PRIME  = 3'd4,
    ST_STREAM = 3'd5
  } com_state_t;

endpackage

// File: rtl/com_stream_counter.sv
// Read pointer and word counter for the result stream.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : prime the pointer to OUT_BASE+1 and clear the count
//              (OUT_BASE itself is issued directly by the controller)
//   step     : one word streamed this cycle; advance pointer and count
//   addr     : next read address to issue
//   last     : count has reached OUT_LEN-1 (current word is the final one)
module com_stream_counter
  import com_port_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int OUT_BASE   = 0,
  parameter int OUT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam int CW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam logic [ADDR_WIDTH-1:0] OUT_BASE_A = ADDR_WIDTH'(OUT_BASE);

  logic [CW-1:0] count;

  // Pointer wraps modulo 2^ADDR_WIDTH naturally; no flag on the read side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= '0;
      count <= '0;
    end else if (load) begin
      addr  <= OUT_BASE_A + 1'b1;
      count <= '0;
    end else if (step) begin
      addr  <= addr + 1'b1;
      count <= count + 1'b1;
    end
  end

  assign last = (count == CW'(OUT_LEN - 1));

endmodule

// File: rtl/com_port_controller.sv
// Device-side end of the 16-bit host link. Loads a host word stream into
// data memory, pulses the cores, waits for completion, then streams a
// fixed window of OUT_LEN result words back to the host.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   com_data_in        : host word
//   data_write_start   : host load phase active, one word per cycle
//   data_write_done    : host load finished (level)
//   com_data_out       : result word to host (0 when not streaming)
//   output_write_start : stream active, com_data_out valid each cycle
//   output_write_done  : high together with the final stream word
//   mem_addr/wdata/we  : data memory write/read port
//   mem_rdata          : memory read data, one cycle after mem_addr
//   proc_start         : one-cycle start pulse to the cores
//   proc_done          : cores finished (level), only looked at in WAIT
//   load_overflow      : sticky, load pointer wrapped past all-ones
//   fsm_state          : current controller state (debug)
//
// Handshake: there is no backpressure in either direction. A word is
// accepted on every rising edge where data_write_start is high in IDLE or
// LOAD; the stream presents one word per cycle while output_write_start is
// high and the host must take it that cycle.
module com_port_controller
  import com_port_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LOAD_BASE  = 0,
  parameter int OUT_BASE   = 0,
  parameter int OUT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COM_WIDTH-1:0]  com_data_in,
  input  logic                  data_write_start,
  input  logic                  data_write_done,
  output logic [COM_WIDTH-1:0]  com_data_out,
  output logic                  output_write_start,
  output logic                  output_write_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [COM_WIDTH-1:0]  mem_wdata,
  output logic                  mem_we,
  input  logic [COM_WIDTH-1:0]  mem_rdata,
  output logic                  proc_start,
  input  logic                  proc_done,
  output logic                  load_overflow,
  output com_state_t            fsm_state
);

  localparam logic [ADDR_WIDTH-1:0] LOAD_BASE_A = ADDR_WIDTH'(LOAD_BASE);
  localparam logic [ADDR_WIDTH-1:0] OUT_BASE_A  = ADDR_WIDTH'(OUT_BASE);

  com_state_t            state;
  logic [ADDR_WIDTH-1:0] load_ptr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_last;
  logic                  write_cycle;

  assign fsm_state = state;

  // Writes are combinational from the host inputs so a word is stored on
  // the same edge it is presented. rst is folded in so the port reads as
  // idle while reset is held, even if the host is driving a load.
  assign write_cycle = !rst && data_write_start &&
                       (state == ST_IDLE || state == ST_LOAD);

  com_stream_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .OUT_BASE   (OUT_BASE),
    .OUT_LEN    (OUT_LEN)
  ) u_stream_counter (
    .clk  (clk),
    .rst  (rst),
    .load (state == ST_PRIME),
    .step (state == ST_STREAM),
    .addr (rd_addr),
    .last (rd_last)
  );

  // load_ptr is returned to LOAD_BASE in KICK, so it already sits at the
  // base whenever the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      load_ptr      <= LOAD_BASE_A;
      load_overflow <= 1'b0;
    end else begin
      if (write_cycle) begin
        load_ptr <= load_ptr + 1'b1;
        if (&load_ptr) load_overflow <= 1'b1;
      end
      case (state)
        ST_IDLE:   if (data_write_start) state <= ST_LOAD;
        ST_LOAD:   if (!data_write_start && data_write_done) state <= ST_KICK;
        ST_KICK: begin
          load_ptr <= LOAD_BASE_A;
          state    <= ST_WAIT;
        end
        ST_WAIT:   if (proc_done) state <= ST_PRIME;
        ST_PRIME:  state <= ST_STREAM;
        ST_STREAM: if (rd_last) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr = '0;
    if (write_cycle)               mem_addr = load_ptr;
    else if (state == ST_PRIME)    mem_addr = OUT_BASE_A;
    else if (state == ST_STREAM)   mem_addr = rd_addr;
  end

  assign mem_we             = write_cycle;
  assign mem_wdata          = write_cycle ? com_data_in : '0;
  assign proc_start         = (state == ST_KICK);
  assign output_write_start = (state == ST_STREAM);
  assign output_write_done  = (state == ST_STREAM) && rd_last;
  assign com_data_out       = (state == ST_STREAM) ? mem_rdata : '0;

endmodule

// File: doc/com_port_controller.md
# com_port_controller

Device-side end of the 16-bit host communication link used by `main`. Accepts a host word stream into shared data memory, pulses the cores to start once loading completes, waits for completion, then streams a fixed result window back to the host. Sits between the top-level `com_*` pins and the data memory write/read port.

## Interface
- `ADDR_WIDTH`, 12: data memory address width.
- `LOAD_BASE`, 0: first memory address written during load.
- `OUT_BASE`, 0: first memory address read during output.
- `OUT_LEN`, 16: number of result words streamed; must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `com_data_in`  in  16  host word.
- `data_write_start`  in  1  host load phase active; one word per cycle.
- `data_write_done`  in  1  host load finished (level).
- `com_data_out`  out  16  result word to host.
- `output_write_start`  out  1  output stream active; `com_data_out` valid every cycle it is high.
- `output_write_done`  out  1  high with the last output word.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  16  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  16  memory read data, valid one cycle after `mem_addr`.
- `proc_start`  out  1  one-cycle pulse to cores.
- `proc_done`  in  1  cores finished (level, held until next `proc_start`).
- `load_overflow`  out  1  sticky: load address wrapped.

## Operation
- States: IDLE, LOAD, KICK, WAIT, PRIME, STREAM.
- IDLE: load pointer = `LOAD_BASE`. `data_write_start`=1 → LOAD, capturing that cycle's word.
- LOAD: every edge with `data_write_start`=1: `mem_we`=1, `mem_addr`=pointer, `mem_wdata`=`com_data_in` (combinational from inputs, registered in memory), pointer+1. Edge with `data_write_start`=0 and `data_write_done`=1 → KICK; word present on that edge is not captured. Both low: stay in LOAD, no write (host stall).
- Pointer arithmetic modulo 2^ADDR_WIDTH; wrap from all-ones to 0 sets `load_overflow` (cleared only by `rst`). Writes continue after wrap.
- KICK: `proc_start`=1 for exactly one cycle → WAIT.
- WAIT: `proc_done`=1 → PRIME. `proc_done` sampled only in WAIT.
- PRIME: `mem_addr`=`OUT_BASE`, read pointer = `OUT_BASE`+1, word count=0 → STREAM.
- STREAM: `output_write_start`=1, `com_data_out`=`mem_rdata` (address issued previous cycle); next address issued each cycle; count+1. When count = `OUT_LEN`-1, `output_write_done`=1 that cycle, → IDLE. Read pointer wraps modulo 2^ADDR_WIDTH without flag.
- `data_write_start` ignored outside IDLE/LOAD.

## Timing
- Reset values: state IDLE, `com_data_out`=0, `output_write_start`=0, `output_write_done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `proc_start`=0, `load_overflow`=0.
- Load: zero-latency, word on edge k written on edge k (memory registers it).
- `data_write_done` sampled → `proc_start` high next cycle.
- `proc_done` sampled in WAIT → PRIME next cycle → first valid output word the cycle after (2-cycle latency).
- Stream lasts exactly `OUT_LEN` consecutive cycles, no bubbles; `output_write_start` and `output_write_done` drop together the cycle after the last word; `com_data_out` returns to 0.
- `OUT_LEN`=1: `output_write_start` and `output_write_done` high in the same single cycle.
- `rst` mid-operation: immediate return to reset values; partial load/stream abandoned; no `proc_start` emitted.

## Structure
- Shared package/definitions header: state encoding constants, `COM_WIDTH`=16, default `ADDR_WIDTH`.
- Single module; output stream counter/pointer may be a sub-module `com_stream_counter` (start address, length, done flag).

## Test plan
- Load 4 words 11,22,33,44 at `LOAD_BASE`=0, then `data_write_done` → memory 0..3 = 11,22,33,44, single `proc_start` pulse the next cycle.
- `proc_done` after 10 cycles, memory 0..3 preloaded 5,6,7,8, `OUT_LEN`=4 → `com_data_out` 5,6,7,8 on 4 consecutive cycles starting 2 cycles after `proc_done`, `output_write_done` with 8 only.
- `ADDR_WIDTH`=4, `LOAD_BASE`=14, load 4 words → writes to 14,15,0,1; `load_overflow`=1 from the edge writing address 0.
- Host stall: `data_write_start` low for 3 cycles mid-load without `data_write_done` → no writes, pointer held, load resumes contiguously.
- `OUT_LEN`=1 → one cycle with both output flags high, then both low.
- Assert `rst` during STREAM word 2 of 4 → all outputs 0 the same cycle; next load restarts at `LOAD_BASE`, `load_overflow`=0.
